// File: rtl/sdram_wr_pkg.sv
// Shared state encoding and default sizing for the SDRAM write feeder.
package sdram_wr_pkg;

  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_ADDR_W      = 20;
  localparam int unsigned DEF_BURST_LEN   = 8;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_FRAME_WORDS = 1024;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } wr_state_e;

  // Occupancy counter width: enough to hold 0..depth inclusive.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// Synchronous show-ahead FIFO with occupancy output; the head word is
// visible on head_o without a read strobe.
module sdram_wr_fifo
  import sdram_wr_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned DEPTH  = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned LVL_W  = lvl_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty;

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared on reset so the exposed head word reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/sdram_wr_feeder.sv
// Stages pixel words and issues fixed-length SDRAM write bursts over a
// wrapping frame address. Define SDRAM_WR_FEEDER_OVF_EN to add the sticky ovf output.
module sdram_wr_feeder
  import sdram_wr_pkg::*;
#(
  parameter  int unsigned DATA_W      = DEF_DATA_W,
  parameter  int unsigned ADDR_W      = DEF_ADDR_W,
  parameter  int unsigned BURST_LEN   = DEF_BURST_LEN,
  parameter  int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter  int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
  localparam int unsigned LVL_W       = lvl_width(FIFO_DEPTH)
) (
  input  logic              S_CLK,
  input  logic              RST,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              write_req,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic              fifo_rd_req,
  output logic [DATA_W-1:0] sdram_data,
  input  logic              write_ack,
  output logic              frame_done,
`ifdef SDRAM_WR_FEEDER_OVF_EN
  output logic              ovf,
`endif
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int unsigned AW1 = ADDR_W + 1;

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic [AW1-1:0]    addr_next;
  logic [LVL_W-1:0]  level;
  logic              fifo_full;

  sdram_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (S_CLK),
    .rst_i   (RST),
    .push_i  (pix_valid),
    .data_i  (pix_data),
    .pop_i   (fifo_rd_req),
    .head_o  (sdram_data),
    .level_o (level),
    .full_o  (fifo_full)
  );

  // One extra bit so the frame-wrap compare cannot alias on overflow.
  assign addr_next = {1'b0, addr_q} + AW1'(BURST_LEN);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (level >= LVL_W'(BURST_LEN)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (write_ack) begin
          state_d = ST_IDLE;
          if (addr_next == AW1'(FRAME_WORDS)) begin
            addr_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_d = addr_next[ADDR_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef SDRAM_WR_FEEDER_OVF_EN
  logic ovf_q;

  // Sticky: any word offered while full is recorded until reset.
  always_ff @(posedge S_CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (pix_valid && fifo_full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`endif

  assign pix_ready  = !fifo_full;
  assign write_req  = (state_q == ST_REQ);
  assign sdram_addr = addr_q;
  assign frame_done = frame_done_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_sdram_wr_feeder.sv
// Directed self-checking bench for sdram_wr_feeder (default parameters).
module tb_sdram_wr_feeder;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ADDR_W      = 20;
  localparam int unsigned BURST_LEN   = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FRAME_WORDS = 1024;
  localparam int unsigned LVL_W       = 5;

  logic              S_CLK;
  logic              RST;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              write_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              fifo_rd_req;
  logic [DATA_W-1:0] sdram_data;
  logic              write_ack;
  logic              frame_done;
  logic [LVL_W-1:0]  fifo_level;
`ifdef SDRAM_WR_FEEDER_OVF_EN
  logic              ovf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_count     = 0;

  sdram_wr_feeder #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .BURST_LEN   (BURST_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .S_CLK       (S_CLK),
    .RST         (RST),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .write_req   (write_req),
    .sdram_addr  (sdram_addr),
    .fifo_rd_req (fifo_rd_req),
    .sdram_data  (sdram_data),
    .write_ack   (write_ack),
    .frame_done  (frame_done),
`ifdef SDRAM_WR_FEEDER_OVF_EN
    .ovf         (ovf),
`endif
    .fifo_level  (fifo_level)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  always @(posedge S_CLK) begin
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic tick();
    @(posedge S_CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    fifo_rd_req = 1'b0;
    write_ack = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic push_words(input int first, input int count);
    for (int i = 0; i < count; i++) begin
      pix_valid = 1'b1;
      pix_data = DATA_W'(first + i);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    pix_valid = 1'b0;
    pix_data = '0;
    fifo_rd_req = 1'b0;
    write_ack = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (write_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_write_req got %b exp 0", write_req);
    end
    tests_run++;
    if (sdram_addr !== ADDR_W'(0)) begin
      tests_failed++; $display("FAIL reset_addr got %h exp 0", sdram_addr);
    end
    tests_run++;
    if (fifo_level !== LVL_W'(0)) begin
      tests_failed++; $display("FAIL reset_level got %0d exp 0", fifo_level);
    end
    tests_run++;
    if (frame_done !== 1'b0 || sdram_data !== DATA_W'(0)) begin
      tests_failed++;
      $display("FAIL reset_outputs frame_done=%b data=%h exp 0/0", frame_done, sdram_data);
    end
`ifdef SDRAM_WR_FEEDER_OVF_EN
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ovf got %b exp 0", ovf);
    end
`endif
    RST = 1'b0;
    tick();
    tests_run++;
    if (pix_ready !== 1'b1 || write_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release pix_ready=%b write_req=%b exp 1/0", pix_ready, write_req);
    end
  endtask

  task automatic test_burst_request();
    int early = 0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      pix_valid = 1'b1;
      pix_data = DATA_W'(i);
      tick();
      if (write_req !== 1'b0) early++;
    end
    pix_valid = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(8) || early != 0) begin
      tests_failed++;
      $display("FAIL burst_fill level=%0d early_req=%0d exp 8/0", fifo_level, early);
    end
    tick();
    tests_run++;
    if (write_req !== 1'b1 || sdram_addr !== ADDR_W'(0)) begin
      tests_failed++;
      $display("FAIL burst_req write_req=%b addr=%h exp 1/0", write_req, sdram_addr);
    end
  endtask

  task automatic test_pop_ack();
    for (int i = 1; i <= 8; i++) begin
      tests_run++;
      if (sdram_data !== DATA_W'(i)) begin
        tests_failed++; $display("FAIL pop_word%0d got %h exp %h", i, sdram_data, DATA_W'(i));
      end
      fifo_rd_req = 1'b1;
      tick();
    end
    fifo_rd_req = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(0) || write_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop_drained level=%0d write_req=%b exp 0/1", fifo_level, write_req);
    end
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    tests_run++;
    if (write_req !== 1'b0 || sdram_addr !== ADDR_W'(8)) begin
      tests_failed++;
      $display("FAIL ack_advance write_req=%b addr=%h exp 0/8", write_req, sdram_addr);
    end
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    tests_run++;
    if (write_req !== 1'b0 || sdram_addr !== ADDR_W'(8) || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_in_idle write_req=%b addr=%h frame_done=%b exp 0/8/0",
               write_req, sdram_addr, frame_done);
    end
  endtask

  task automatic test_full();
    int err = 0;
    do_reset();
    push_words(32'h100, 16);
    tests_run++;
    if (pix_ready !== 1'b0 || fifo_level !== LVL_W'(16)) begin
      tests_failed++;
      $display("FAIL full_flag pix_ready=%b level=%0d exp 0/16", pix_ready, fifo_level);
    end
    pix_valid = 1'b1;
    pix_data = DATA_W'(16'hDEAD);
    tick();
    pix_valid = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(16) || sdram_data !== DATA_W'(16'h0100)) begin
      tests_failed++;
      $display("FAIL full_drop level=%0d head=%h exp 16/0100", fifo_level, sdram_data);
    end
`ifdef SDRAM_WR_FEEDER_OVF_EN
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++; $display("FAIL full_ovf got %b exp 1", ovf);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      if (sdram_data !== DATA_W'(32'h100 + i)) err++;
      fifo_rd_req = 1'b1;
      tick();
    end
    fifo_rd_req = 1'b0;
    tests_run++;
    if (err != 0 || fifo_level !== LVL_W'(0)) begin
      tests_failed++;
      $display("FAIL full_drain bad_words=%0d level=%0d exp 0/0", err, fifo_level);
    end
  endtask

  task automatic test_simultaneous();
    int err = 0;
    do_reset();
    push_words(32'h10, 5);
    pix_valid = 1'b1;
    pix_data = DATA_W'(16'h0015);
    fifo_rd_req = 1'b1;
    tick();
    pix_valid = 1'b0;
    fifo_rd_req = 1'b0;
    tests_run++;
    if (fifo_level !== LVL_W'(5) || sdram_data !== DATA_W'(16'h0011)) begin
      tests_failed++;
      $display("FAIL simul_push_pop level=%0d head=%h exp 5/0011", fifo_level, sdram_data);
    end
    for (int i = 0; i < 5; i++) begin
      if (sdram_data !== DATA_W'(32'h11 + i)) err++;
      fifo_rd_req = 1'b1;
      tick();
    end
    fifo_rd_req = 1'b1;
    tick();
    fifo_rd_req = 1'b0;
    tests_run++;
    if (err != 0 || fifo_level !== LVL_W'(0) || sdram_data !== DATA_W'(0)) begin
      tests_failed++;
      $display("FAIL empty_pop bad_words=%0d level=%0d data=%h exp 0/0/0000",
               err, fifo_level, sdram_data);
    end
  endtask

  task automatic test_frame();
    int addr_err = 0;
    int data_err = 0;
    int fd_err = 0;
    int timeouts = 0;
    int fd_start;
    int n;
    do_reset();
    fd_start = fd_count;
    for (int b = 0; b < int'(FRAME_WORDS / BURST_LEN); b++) begin
      push_words(b * 8, 8);
      n = 0;
      while (write_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) timeouts++;
      if (sdram_addr !== ADDR_W'(b * 8)) addr_err++;
      for (int w = 0; w < 8; w++) begin
        if (sdram_data !== DATA_W'(b * 8 + w)) data_err++;
        fifo_rd_req = 1'b1;
        tick();
      end
      fifo_rd_req = 1'b0;
      if (sdram_addr !== ADDR_W'(b * 8) || write_req !== 1'b1) addr_err++;
      write_ack = 1'b1;
      tick();
      write_ack = 1'b0;
      if (b == 127) begin
        tests_run++;
        if (sdram_addr !== ADDR_W'(0) || frame_done !== 1'b1 || write_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL frame_wrap addr=%h frame_done=%b write_req=%b exp 0/1/0",
                   sdram_addr, frame_done, write_req);
        end
      end else if (frame_done !== 1'b0) begin
        fd_err++;
      end
    end
    tick();
    tests_run++;
    if (frame_done !== 1'b0 || (fd_count - fd_start) != 1 || fd_err != 0) begin
      tests_failed++;
      $display("FAIL frame_pulse frame_done=%b pulses=%0d early=%0d exp 0/1/0",
               frame_done, fd_count - fd_start, fd_err);
    end
    tests_run++;
    if (addr_err != 0 || data_err != 0 || timeouts != 0) begin
      tests_failed++;
      $display("FAIL frame_stream addr_err=%0d data_err=%0d timeouts=%0d exp 0/0/0",
               addr_err, data_err, timeouts);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    push_words(32'h200, 8);
    tick();
    for (int w = 0; w < 8; w++) begin
      fifo_rd_req = 1'b1;
      tick();
    end
    fifo_rd_req = 1'b0;
    write_ack = 1'b1;
    tick();
    write_ack = 1'b0;
    push_words(32'h300, 10);
    tests_run++;
    if (write_req !== 1'b1 || fifo_level !== LVL_W'(10) || sdram_addr !== ADDR_W'(8)) begin
      tests_failed++;
      $display("FAIL midrst_setup write_req=%b level=%0d addr=%h exp 1/10/8",
               write_req, fifo_level, sdram_addr);
    end
    RST = 1'b1;
    #2;
    tests_run++;
    if (write_req !== 1'b0 || fifo_level !== LVL_W'(0) || sdram_addr !== ADDR_W'(0)
        || sdram_data !== DATA_W'(0)) begin
      tests_failed++;
      $display("FAIL midrst_async write_req=%b level=%0d addr=%h data=%h exp 0/0/0/0",
               write_req, fifo_level, sdram_addr, sdram_data);
    end
    tick();
    RST = 1'b0;
    tick();
    tests_run++;
    if (pix_ready !== 1'b1 || write_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_release pix_ready=%b write_req=%b exp 1/0", pix_ready, write_req);
    end
  endtask

  initial begin
    test_reset();
    test_burst_request();
    test_pop_ack();
    test_full();
    test_simultaneous();
    test_frame();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_wr_feeder.md
SDRAM_WR_FEEDER -- requirements
Module: sdram_wr_feeder

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, word width; ADDR_W, default 20, SDRAM linear word address width; BURST_LEN, default 8, words per write burst; FIFO_DEPTH, default 16, staging depth (power of 2, >= 2*BURST_LEN); FRAME_WORDS, default 1024, words per frame (a multiple of BURST_LEN).
REQ-002 SHALL have port S_CLK, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port pix_valid, input, 1, upstream word valid.
REQ-005 SHALL have port pix_data, input, DATA_W, upstream word.
REQ-006 SHALL have port pix_ready, output, 1, high when the FIFO is not full.
REQ-007 SHALL have port write_req, output, 1, burst request to the SDRAM top.
REQ-008 SHALL have port sdram_addr, output, ADDR_W, burst start address.
REQ-009 SHALL have port fifo_rd_req, input, 1, word pop strobe from the SDRAM top.
REQ-010 SHALL have port sdram_data, output, DATA_W, FIFO head word.
REQ-011 SHALL have port write_ack, input, 1, burst-complete pulse from the SDRAM top.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse on frame wrap.
REQ-013 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, current occupancy.

Function
REQ-014 SHALL push pix_data when pix_valid && pix_ready; pix_valid while full is ignored.
REQ-015 SHALL present the FIFO head on sdram_data combinationally (show-ahead); on fifo_rd_req with level>0, pop so the next word appears the following cycle.
REQ-016 SHALL ignore fifo_rd_req when empty: no level change, sdram_data holds.
REQ-017 SHALL, on a simultaneous push and pop, perform both and leave fifo_level unchanged.
REQ-018 SHALL implement FSM IDLE, REQ: IDLE->REQ when fifo_level >= BURST_LEN; REQ->IDLE on write_ack.
REQ-019 SHALL drive write_req high exactly while in REQ; sdram_addr is stable throughout REQ.
REQ-020 SHALL, on write_ack in REQ, advance sdram_addr by BURST_LEN the next cycle; write_ack in IDLE is ignored.
REQ-021 SHALL, when the advanced address would equal FRAME_WORDS, load 0 instead and pulse frame_done for one cycle.
REQ-022 SHALL re-enter REQ no earlier than one cycle after write_ack (minimum one IDLE cycle between bursts).

Reset
REQ-023 SHALL, on RST assertion (including mid-burst), asynchronously force: state IDLE, write_req 0, sdram_addr 0, FIFO emptied, fifo_level 0, pix_ready 1 after release, frame_done 0, sdram_data 0.

Configuration
REQ-024 SHALL, with SDRAM_WR_FEEDER_OVF_EN defined, add output ovf (1 bit) set sticky when pix_valid is high while full, cleared only by RST; without the macro the port and logic are absent and behaviour is otherwise identical.

Structure
REQ-025 SHALL place the FSM state enum and default width constants in package sdram_wr_pkg.
REQ-026 SHALL instantiate one sub-module, sdram_wr_fifo, a synchronous show-ahead FIFO with level output; the FSM and address counter sit in sdram_wr_feeder.

Verification
REQ-027 Reset then push 8 words 0x0001..0x0008 -> write_req rises one cycle after level reaches 8, sdram_addr=0.
REQ-028 Pop 8 via fifo_rd_req then write_ack -> sdram_data steps 0x0001..0x0008 one per pop, write_req drops, sdram_addr=8.
REQ-029 Stream 1024 words with prompt acks -> 128 bursts, after the last ack sdram_addr=0 and frame_done pulses exactly once.
REQ-030 Push 16 words with no pops -> pix_ready=0, a 17th word is dropped, fifo_level=16; with SDRAM_WR_FEEDER_OVF_EN, ovf=1.
REQ-031 Push and pop in the same cycle at level 5 -> level stays 5; fifo_rd_req at level 0 -> level stays 0, sdram_data unchanged.
REQ-032 Assert RST during REQ with level 10 -> write_req=0 immediately, level=0, sdram_addr=0.
